// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit replacement hysteresis,
// registered lookups (write-first against same-cycle updates) and saturating hit/miss counters.
module branch_target_buffer #(
  parameter int INDEX_BITS  = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lookup_valid,
  input  logic [31:0]            lookup_PC,
  output logic                   lookup_done,
  output logic                   hit,
  output logic [31:0]            predicted_target,
  input  logic [63:0]            tag_and_target_address,
  input  logic                   valid_tag_and_target,
  input  logic                   invalidate_all,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_conf   [ENTRIES];

  function automatic logic [1:0] conf_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] cnt_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [31:0]           w_upd_pc;
  logic [31:0]           w_upd_target;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_W-1:0]      w_upd_tag;
  logic                  w_upd_en;
  logic [TAG_W-1:0]      w_new_tag;
  logic [31:0]           w_new_target;
  logic [1:0]            w_new_conf;

  assign w_upd_pc     = tag_and_target_address[63:32];
  assign w_upd_target = tag_and_target_address[31:0];
  assign w_upd_idx    = w_upd_pc[INDEX_BITS-1:0];
  assign w_upd_tag    = w_upd_pc[31:INDEX_BITS];
  assign w_upd_en     = valid_tag_and_target && !invalidate_all;

  // Next state of the entry being updated; unchanged tag/target when hysteresis blocks a replace.
  always_comb begin
    w_new_tag    = r_tag[w_upd_idx];
    w_new_target = r_target[w_upd_idx];
    w_new_conf   = r_conf[w_upd_idx];
    if (!r_valid[w_upd_idx]) begin
      w_new_tag    = w_upd_tag;
      w_new_target = w_upd_target;
      w_new_conf   = 2'd1;
    end else if (r_tag[w_upd_idx] == w_upd_tag) begin
      w_new_target = w_upd_target;
      w_new_conf   = conf_inc(r_conf[w_upd_idx]);
    end else if (r_conf[w_upd_idx] == 2'd0) begin
      w_new_tag    = w_upd_tag;
      w_new_target = w_upd_target;
      w_new_conf   = 2'd1;
    end else begin
      w_new_conf   = r_conf[w_upd_idx] - 2'd1;
    end
  end

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic                  w_fwd;
  logic                  w_eff_valid;
  logic [TAG_W-1:0]      w_eff_tag;
  logic [31:0]           w_eff_target;
  logic                  w_hit;

  assign w_lk_idx = lookup_PC[INDEX_BITS-1:0];
  assign w_lk_tag = lookup_PC[31:INDEX_BITS];

  // Write-first: a same-index update is forwarded into the lookup path.
  assign w_fwd        = w_upd_en && (w_upd_idx == w_lk_idx);
  assign w_eff_valid  = w_fwd ? 1'b1         : r_valid[w_lk_idx];
  assign w_eff_tag    = w_fwd ? w_new_tag    : r_tag[w_lk_idx];
  assign w_eff_target = w_fwd ? w_new_target : r_target[w_lk_idx];
  assign w_hit        = w_eff_valid && (w_eff_tag == w_lk_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid          <= '0;
      for (int i = 0; i < ENTRIES; i++) r_conf[i] <= 2'd0;
      lookup_done      <= 1'b0;
      hit              <= 1'b0;
      predicted_target <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      if (invalidate_all) begin
        r_valid <= '0;
        for (int i = 0; i < ENTRIES; i++) r_conf[i] <= 2'd0;
      end else if (valid_tag_and_target) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_conf[w_upd_idx]  <= w_new_conf;
      end
      lookup_done      <= lookup_valid;
      hit              <= lookup_valid && w_hit;
      predicted_target <= (lookup_valid && w_hit) ? w_eff_target : 32'd0;
      if (lookup_valid) begin
        if (w_hit) hit_count  <= cnt_inc(hit_count);
        else       miss_count <= cnt_inc(miss_count);
      end
    end
  end

  // Tag/target storage carries no reset; validity alone qualifies it.
  always_ff @(posedge clk) begin
    if (!reset && w_upd_en) begin
      r_tag[w_upd_idx]    <= w_new_tag;
      r_target[w_upd_idx] <= w_new_target;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: reference model feeds an expected-result
// scoreboard each cycle; observed outputs are queued after each edge and compared per scenario.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_PC = '0;
  logic        lookup_done;
  logic        hit;
  logic [31:0] predicted_target;
  logic [63:0] tag_and_target_address = '0;
  logic        valid_tag_and_target = 1'b0;
  logic        invalidate_all = 1'b0;
  logic [3:0]  hit_count;
  logic [3:0]  miss_count;

  branch_target_buffer #(.INDEX_BITS(3), .COUNT_WIDTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .lookup_valid           (lookup_valid),
    .lookup_PC              (lookup_PC),
    .lookup_done            (lookup_done),
    .hit                    (hit),
    .predicted_target       (predicted_target),
    .tag_and_target_address (tag_and_target_address),
    .valid_tag_and_target   (valid_tag_and_target),
    .invalidate_all         (invalidate_all),
    .hit_count              (hit_count),
    .miss_count             (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        hit;
    logic [31:0] tgt;
    logic [3:0]  hc;
    logic [3:0]  mc;
  } obs_t;

  obs_t obs;
  assign obs = {lookup_done, hit, predicted_target, hit_count, miss_count};

  obs_t exp_q[$];
  obs_t got_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        m_valid [8];
  logic [28:0] m_tag   [8];
  logic [31:0] m_tgt   [8];
  logic [1:0]  m_conf  [8];
  logic [3:0]  m_hc = '0;
  logic [3:0]  m_mc = '0;

  initial for (int i = 0; i < 8; i++) begin
    m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_conf[i] = 2'd0;
  end

  // Drive one cycle of stimulus, push the model's expectation, then capture the DUT outputs.
  task automatic cycle(input logic rst_i, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic inv);
    obs_t e;
    int   ui, li;
    logic h;
    reset = rst_i; lookup_valid = lv; lookup_PC = lpc;
    valid_tag_and_target = uv; tag_and_target_address = {upc, utgt}; invalidate_all = inv;
    e = '0;
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_conf[i] = 2'd0; end
      m_hc = '0; m_mc = '0;
    end else begin
      if (uv && !inv) begin
        ui = int'(upc[2:0]);
        if (!m_valid[ui] || (m_tag[ui] != upc[31:3] && m_conf[ui] == 2'd0)) begin
          m_valid[ui] = 1'b1; m_tag[ui] = upc[31:3]; m_tgt[ui] = utgt; m_conf[ui] = 2'd1;
        end else if (m_tag[ui] == upc[31:3]) begin
          m_tgt[ui] = utgt;
          if (m_conf[ui] != 2'd3) m_conf[ui] = m_conf[ui] + 2'd1;
        end else begin
          m_conf[ui] = m_conf[ui] - 2'd1;
        end
      end
      if (lv) begin
        li = int'(lpc[2:0]);
        h = m_valid[li] && (m_tag[li] == lpc[31:3]);
        e.done = 1'b1;
        e.hit  = h;
        e.tgt  = h ? m_tgt[li] : 32'd0;
        if (h) begin if (m_hc != 4'hF) m_hc = m_hc + 4'd1; end
        else   begin if (m_mc != 4'hF) m_mc = m_mc + 4'd1; end
      end
      if (inv) for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_conf[i] = 2'd0; end
    end
    e.hc = m_hc; e.mc = m_mc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    got_q.push_back(obs);
  endtask

  task automatic test_reset();
    obs_t e, g;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== obs_t'(0)) begin
      errors++; $display("FAIL reset_state got=%h required=%h", got_q[$], obs_t'(0));
    end
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== {1'b1, 1'b0, 32'h0, 4'h0, 4'h1}) begin
      errors++; $display("FAIL reset_first_miss got=%h required=%h", got_q[$], {1'b1, 1'b0, 32'h0, 4'h0, 4'h1});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_sb got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_update();
    obs_t e, g;
    cycle(0, 0, 0, 1, 32'h10, 32'h40, 0);
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== {1'b1, 1'b1, 32'h40, 4'h1, 4'h1}) begin
      errors++; $display("FAIL update_hit got=%h required=%h", got_q[$], {1'b1, 1'b1, 32'h40, 4'h1, 4'h1});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL update_sb got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_hysteresis();
    obs_t e, g;
    cycle(0, 0, 0, 1, 32'h10, 32'h40, 0);
    cycle(0, 0, 0, 1, 32'h10, 32'h40, 0);
    cycle(0, 0, 0, 1, 32'h18, 32'h80, 0);
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    checks++;
    if ({got_q[$].hit, got_q[$].tgt} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL hyst_resist got=%h required=%h", {got_q[$].hit, got_q[$].tgt}, {1'b1, 32'h40});
    end
    cycle(0, 0, 0, 1, 32'h18, 32'h80, 0);
    cycle(0, 0, 0, 1, 32'h18, 32'h80, 0);
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    checks++;
    if ({got_q[$].hit, got_q[$].tgt} !== {1'b1, 32'h40}) begin
      errors++; $display("FAIL hyst_conf0_keep got=%h required=%h", {got_q[$].hit, got_q[$].tgt}, {1'b1, 32'h40});
    end
    cycle(0, 0, 0, 1, 32'h18, 32'h80, 0);
    cycle(0, 1, 32'h18, 0, 0, 0, 0);
    checks++;
    if ({got_q[$].hit, got_q[$].tgt} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL hyst_replaced got=%h required=%h", {got_q[$].hit, got_q[$].tgt}, {1'b1, 32'h80});
    end
    cycle(0, 1, 32'h10, 0, 0, 0, 0);
    checks++;
    if ({got_q[$].done, got_q[$].hit, got_q[$].tgt} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL hyst_old_miss got=%h required=%h", {got_q[$].done, got_q[$].hit, got_q[$].tgt}, {1'b1, 1'b0, 32'h0});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL hyst_sb got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_write_first();
    obs_t e, g;
    cycle(0, 1, 32'h23, 1, 32'h23, 32'h99, 0);
    checks++;
    if ({got_q[$].done, got_q[$].hit, got_q[$].tgt} !== {1'b1, 1'b1, 32'h99}) begin
      errors++; $display("FAIL write_first got=%h required=%h", {got_q[$].done, got_q[$].hit, got_q[$].tgt}, {1'b1, 1'b1, 32'h99});
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({got_q[$].done, got_q[$].hit, got_q[$].tgt} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL idle_outputs got=%h required=%h", {got_q[$].done, got_q[$].hit, got_q[$].tgt}, {1'b0, 1'b0, 32'h0});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wf_sb got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back_invalidate();
    obs_t e, g;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 32'h100 + 32'(i), 32'h1000 + 32'(i), 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h100 + 32'(i), 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== {1'b1, 1'b1, 32'h1007, 4'h8, 4'h0}) begin
      errors++; $display("FAIL b2b_last got=%h required=%h", got_q[$], {1'b1, 1'b1, 32'h1007, 4'h8, 4'h0});
    end
    cycle(0, 1, 32'h105, 1, 32'h05, 32'h55, 1);
    checks++;
    if ({got_q[$].hit, got_q[$].tgt} !== {1'b1, 32'h1005}) begin
      errors++; $display("FAIL inv_pre_state got=%h required=%h", {got_q[$].hit, got_q[$].tgt}, {1'b1, 32'h1005});
    end
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h100 + 32'(i), 0, 0, 0, 0);
    cycle(0, 1, 32'h05, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== {1'b1, 1'b0, 32'h0, 4'h9, 4'h9}) begin
      errors++; $display("FAIL inv_all_miss got=%h required=%h", got_q[$], {1'b1, 1'b0, 32'h0, 4'h9, 4'h9});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL inv_sb got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_saturation_reset();
    obs_t e, g;
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h30, 32'h77, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 32'h30, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== {1'b1, 1'b1, 32'h77, 4'hF, 4'h0}) begin
      errors++; $display("FAIL hit_saturate got=%h required=%h", got_q[$], {1'b1, 1'b1, 32'h77, 4'hF, 4'h0});
    end
    cycle(1, 1, 32'h30, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== obs_t'(0)) begin
      errors++; $display("FAIL reset_drops_lookup got=%h required=%h", got_q[$], obs_t'(0));
    end
    cycle(0, 1, 32'h30, 0, 0, 0, 0);
    checks++;
    if (got_q[$] !== {1'b1, 1'b0, 32'h0, 4'h0, 4'h1}) begin
      errors++; $display("FAIL reset_cleared_valid got=%h required=%h", got_q[$], {1'b1, 1'b0, 32'h0, 4'h0, 4'h1});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL sat_sb got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_random();
    obs_t e, g;
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), 32'($urandom),
            1'($urandom_range(0, 39) == 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL random_sb got=%h exp=%h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_hysteresis();
    test_write_first();
    test_back_to_back_invalidate();
    test_saturation_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
